jt51_lin2exp_ser: RTL and testbench
===================================

# jt51_lin2exp_ser

Multi-channel, pipelined linear-to-floating-point converter with a YM3012-style serial DAC output. It accepts frames of CH signed linear samples through a valid/ready handshake and double-buffers them. Each sample is normalised to an MW-bit mantissa and an EW-bit exponent, then shifted out bit-serially in fixed-length slots. It sits between the final channel mixer and the external serial DAC pins.

## Interface
- IW, 16, input sample width (signed two's complement); must equal MW + 2^EW − 2
- MW, 10, mantissa width
- EW, 3, exponent width; EXPMAX = 2^EW − 1
- CH, 2, channels per frame
- PAD, 3, leading zero bits per serial slot; SLOT = PAD + MW + EW
- rst  in  1  synchronous reset, active-high
- clk  in  1  single clock, rising edge
- cen  in  1  clock enable; all state advances only on clk edges with cen=1 ("ticks")
- din  in  CH*IW  frame; channel k at din[k*IW +: IW]
- din_valid  in  1  frame valid
- din_ready  out  1  buffer can accept a frame
- sd  out  1  serial data
- sync  out  1  high during bit 0 of every slot
- ch  out  clog2(CH) (min 1)  channel index of the current slot
- man  out  MW  mantissa of the current slot, registered
- exp  out  EW  exponent of the current slot, registered
- busy  out  1  shifter active (state SHIFT)

## Operation
- Conversion (combinational, one shared instance): the top EXPMAX bits lin[IW−1:MW−1] are examined. Let r = number of bits directly below the MSB that equal the MSB, r ∈ [0, EXPMAX−1]. Then exp = EXPMAX − r and man = lin[MW−2+exp : exp−1]. Sign is preserved in man's MSB. Truncation only; no rounding or saturation.
- Storage: input buffer IB (one frame + full flag) and frame latch FL (one frame).
- Accept: a tick with din_valid && din_ready writes din to IB and sets full.
- din_ready = !full, registered. It is 0 while rst=1 and 1 on the first tick after reset.
- FSM states: IDLE and SHIFT, with counters bit (0..SLOT−1) and ch (0..CH−1).
- IDLE: sd=0, sync=0, busy=0. On a tick with full=1:
  - copy IB→FL and clear full;
  - load the shifter with the ch0 word;
  - set ch=0, bit=0; go to SHIFT.
- Slot word, shifted out LSB-first one bit per tick: PAD zeros, then man[0..MW−1], then exp[0..EW−1]. man/exp outputs update at every slot load.
- SHIFT, tick with bit=SLOT−1:
  - if ch<CH−1: load the next channel from FL, ch+1;
  - else if full: copy IB→FL, clear full, load ch0; the output is gapless;
  - else: go to IDLE, and sd, sync and ch return to 0.
- Simultaneous events: an accept and an IB→FL transfer cannot coincide, because ready=0 while full. After a transfer, ready rises on the next tick.
- Reset (mid-slot or otherwise): FSM goes to IDLE and full is cleared. sd, sync, ch, man, exp, busy are all 0. The partially shifted frame and the buffered frame are discarded.

## Timing
- Acceptance at tick T with the FSM idle: full=1 after T. At tick T+1, slot 0 bit 0 appears on sd with sync=1.
- Each slot lasts SLOT ticks; a frame lasts CH*SLOT ticks.
- Continuous throughput needs a new frame accepted before the last tick of the current frame.
- With cen=0, all outputs and state hold. din is not sampled when cen=0.
- Output latency from FL to sd is 0 ticks: outputs are registered at the load tick.

## Test plan
- Conversion sweep, single channel, default parameters:
  - 0x7FFF → man 0x1FF, exp 7
  - 0x8000 → man 0x200, exp 7
  - 0x1234 → man 0x123, exp 5
  - 0x0200 → man 0x100, exp 2
  - 0x0100 → man 0x100, exp 1
  - 0xFFC0 → man 0x3C0, exp 1
  - 0x0000 → man 0, exp 1
- Serial format: ch0=0x0200 → sd over 16 ticks = 0,0,0, 0,0,0,0,0,0,0,0,1,0, 0,1,0. sync high only at tick 1 of the slot; ch=0, then ch=1 for the next 16 ticks.
- Back-to-back frames: second frame accepted mid-way through the first → sync pulses every 16 ticks with no idle gap. After the final frame, busy drops and sd=0.
- Backpressure: hold din_valid=1 with three frames queued → din_ready low from acceptance of frame 2 until the frame 1→2 transfer tick. No frame is lost or duplicated, checked by scoreboard.
- cen gating: cen toggling 1-of-3 → bit sequence identical to cen=1, stretched 3×. din is ignored on cen=0 cycles.
- Reset mid-slot at bit 7 of ch1 → all outputs 0 on the next edge and din_ready=1 after reset releases. A new frame restarts at ch0 bit 0.

Source files
------------

// File: rtl/jt51_lin2exp_ser_if.sv
// Frame input channel of the linear-to-exponent serialiser: CH packed samples
// with a valid/ready handshake.
interface jt51_lin2exp_ser_if #(
   parameter int IW = 16,
   parameter int CH = 2
);
   logic [CH*IW-1:0] din;
   logic             din_valid;
   logic             din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/jt51_lin2exp_ser.sv
// Multi-channel linear to mantissa/exponent converter with a YM3012-style
// serial output. State table: IDLE | waiting for a buffered frame; SHIFT | slot bits leaving on sd.
module jt51_lin2exp_ser #(
   parameter int IW  = 16,
   parameter int MW  = 10,
   parameter int EW  = 3,
   parameter int CH  = 2,
   parameter int PAD = 3,
   parameter int CW  = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cen,
   jt51_lin2exp_ser_if.slave     bus,
   output logic                  sd,
   output logic                  sync,
   output logic [CW-1:0]         ch,
   output logic [MW-1:0]         man,
   output logic [EW-1:0]         exp,
   output logic                  busy
);
   localparam int SLOT   = PAD + MW + EW;
   localparam int EXPMAX = 2**EW - 1;
   localparam int BW     = $clog2(SLOT);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]       state;
   logic             full;
   logic [CH*IW-1:0] ib;
   logic [CH*IW-1:0] fl;
   logic [BW-1:0]    bit_cnt;
   logic [SLOT-1:0]  shreg;

   logic             last_bit;
   logic             last_ch;
   logic             from_ib;
   logic             accept;
   logic             xfer;
   logic             load;
   logic             full_nxt;
   logic [CW-1:0]    ch_nxt;
   logic [IW-1:0]    cnv_lin;
   logic [EW-1:0]    cnv_r;
   logic             cnv_run;
   logic [EW-1:0]    cnv_exp;
   logic [MW-1:0]    cnv_man;
   logic [SLOT-1:0]  word;

   assign last_bit = (bit_cnt == BW'(SLOT - 1));
   assign last_ch  = (ch == CW'(CH - 1));
   assign from_ib  = (state == ST_IDLE) || last_ch;
   assign accept   = bus.din_valid && bus.din_ready;
   assign xfer     = full && ((state == ST_IDLE) || (last_bit && last_ch));
   assign load     = (state == ST_IDLE) ? full : (last_bit && (!last_ch || full));
   assign full_nxt = xfer ? 1'b0 : (accept ? 1'b1 : full);
   assign ch_nxt   = from_ib ? '0 : ch + 1'b1;

   // Single converter, fed by whichever sample the next slot load needs.
   always_comb begin
      cnv_lin = ib[IW-1:0];
      if (!from_ib) begin
         for (int k = 0; k < CH; k++) begin
            if (ch_nxt == CW'(k)) cnv_lin = fl[k*IW +: IW];
         end
      end
   end

   // Count sign-repeat bits below the MSB; the window is capped so exp >= 1.
   always_comb begin
      cnv_r   = '0;
      cnv_run = 1'b1;
      for (int i = 1; i < EXPMAX; i++) begin
         if (cnv_run && (cnv_lin[IW-1-i] == cnv_lin[IW-1])) cnv_r = cnv_r + 1'b1;
         else cnv_run = 1'b0;
      end
      cnv_exp = EW'(EXPMAX) - cnv_r;
      cnv_man = MW'(cnv_lin >> (cnv_exp - 1'b1));
      word    = {cnv_exp, cnv_man, {PAD{1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (cen) begin
         if (accept) ib <= bus.din;
         if (xfer)   fl <= ib;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         full          <= 1'b0;
         bus.din_ready <= 1'b0;
         bit_cnt       <= '0;
         shreg         <= '0;
         sd            <= 1'b0;
         sync          <= 1'b0;
         ch            <= '0;
         man           <= '0;
         exp           <= '0;
         busy          <= 1'b0;
      end else if (cen) begin
         full          <= full_nxt;
         bus.din_ready <= !full_nxt;
         if (load) begin
            // The first bit leaves on the load tick itself, so sd is the word LSB.
            state   <= ST_SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            ch      <= ch_nxt;
            man     <= cnv_man;
            exp     <= cnv_exp;
            sd      <= word[0];
            shreg   <= word >> 1;
            sync    <= 1'b1;
         end else if (state == ST_SHIFT) begin
            if (last_bit) begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               bit_cnt <= '0;
               sd      <= 1'b0;
               sync    <= 1'b0;
               ch      <= '0;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
               sd      <= shreg[0];
               shreg   <= shreg >> 1;
               sync    <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_jt51_lin2exp_ser.sv
// Directed bench for jt51_lin2exp_ser: hand-computed conversions checked
// through a slot decoder and an ordered expectation queue.
module tb_jt51_lin2exp_ser;
   localparam int IW = 16, MW = 10, EW = 3, CH = 2, PAD = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b1;
   logic       sd, sync, busy;
   logic       ch;
   logic [9:0] man;
   logic [2:0] exp;

   jt51_lin2exp_ser_if #(.IW(IW), .CH(CH)) bus();

   jt51_lin2exp_ser #(.IW(IW), .MW(MW), .EW(EW), .CH(CH), .PAD(PAD)) dut (
      .clk(clk), .rst(rst), .cen(cen), .bus(bus),
      .sd(sd), .sync(sync), .ch(ch), .man(man), .exp(exp), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       c;
      logic [9:0] m;
      logic [2:0] e;
   } slot_t;

   slot_t       exp_q[$];
   logic [31:0] feed_q[$];
   int          run_q[$];
   int          total = 0;
   int          bad   = 0;

   logic        feed_en = 1'b0, mon_en = 1'b0;
   logic        f_valid = 1'b0, m_valid = 1'b0, f_will = 1'b0;
   logic [31:0] f_din = '0, m_din = '0;

   assign bus.din       = feed_en ? f_din : m_din;
   assign bus.din_valid = feed_en ? f_valid : m_valid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int   tick_cnt = 0;
   logic tick_q   = 1'b0;
   always @(posedge clk) begin
      tick_q <= cen | rst;
      if (cen) tick_cnt <= tick_cnt + 1;
   end

   // Frame source: holds each queued frame until a tick accepts it.
   int acc_cnt = 0, acc_tick = 0;
   always begin
      @(negedge clk);
      f_will = f_valid && feed_en && bus.din_ready && cen && !rst;
      @(posedge clk);
      #1;
      if (f_will) begin
         void'(feed_q.pop_front());
         acc_cnt++;
         acc_tick = tick_cnt;
      end
      if (feed_en && feed_q.size() > 0) begin
         f_din   = feed_q[0];
         f_valid = 1'b1;
      end else begin
         f_valid = 1'b0;
      end
   end

   // Slot decoder: rebuilds each 16-bit slot from sd on ticks.
   logic [15:0] bits;
   logic [17:0] snap = '0;
   wire  [17:0] outs = {bus.din_ready, sd, sync, ch, man, exp, busy};
   int          nbits = 0, tick_since = 0, cyc_since = 0, cyc_period = 0, falls = 0, rdy_run = 0;
   logic        first = 1'b1, prev_busy = 1'b0;
   slot_t       s_cur;

   task automatic finish_slot();
      slot_t w;
      chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         chk("slot_ch",   s_cur.c, w.c);
         chk("slot_man",  s_cur.m, w.m);
         chk("slot_exp",  s_cur.e, w.e);
         chk("slot_bits", bits, {w.e, w.m, 3'b000});
      end
   endtask

   always @(negedge clk) begin
      if (!bus.din_ready) rdy_run++;
      else if (rdy_run > 0) begin
         run_q.push_back(rdy_run);
         rdy_run = 0;
      end
      cyc_since++;
      if (!mon_en) begin
         nbits = 0; first = 1'b1; prev_busy = 1'b0;
      end else if (!tick_q) begin
         chk("hold", outs, snap);
      end else if (!busy) begin
         if (prev_busy) falls++;
         chk("idle_out", {sd, sync, ch}, 0);
         first = 1'b1; nbits = 0; prev_busy = 1'b0;
      end else begin
         if (sync) begin
            if (first) chk("start_latency", tick_cnt - acc_tick, 1);
            else begin
               chk("slot_len", nbits, 16);
               chk("sync_period", tick_since, 16);
               cyc_period = cyc_since;
            end
            first = 1'b0; nbits = 0; tick_since = 0; cyc_since = 0;
            s_cur = '{c: ch, m: man, e: exp};
         end
         if (nbits < 16) bits[nbits] = sd;
         nbits++;
         tick_since++;
         if (nbits == 16) finish_slot();
         prev_busy = 1'b1;
      end
      snap = outs;
   end

   task automatic push_frame(input logic [15:0] d0, input logic [9:0] m0, input logic [2:0] e0,
                             input logic [15:0] d1, input logic [9:0] m1, input logic [2:0] e1);
      feed_q.push_back({d1, d0});
      exp_q.push_back('{c: 1'b0, m: m0, e: e0});
      exp_q.push_back('{c: 1'b1, m: m1, e: e1});
   endtask

   task automatic wait_drain(input int budget, input int div);
      int c = 0;
      bit done = 1'b0;
      while (!done && c < budget) begin
         cen = (c % div == 0);
         step();
         c++;
         done = feed_q.size() == 0 && exp_q.size() == 0 && !busy && !f_valid;
      end
      cen = 1'b1;
      chk("drain", done, 1);
   endtask

   initial begin
      int  f0;
      bit  found;
      rst = 1'b1;
      cen = 1'b1;
      repeat (3) step();
      chk("rst_sd", sd, 0);
      chk("rst_sync", sync, 0);
      chk("rst_ch", ch, 0);
      chk("rst_man", man, 0);
      chk("rst_exp", exp, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", bus.din_ready, 0);
      rst = 1'b0;
      step();
      chk("ready_after_rst", bus.din_ready, 1);

      // A frame offered only on cen=0 cycles must not be taken.
      cen     = 1'b0;
      m_din   = 32'h1234_1234;
      m_valid = 1'b1;
      repeat (4) step();
      m_valid = 1'b0;
      cen     = 1'b1;
      repeat (2) step();
      chk("cen0_ready", bus.din_ready, 1);
      chk("cen0_busy", busy, 0);

      mon_en  = 1'b1;
      feed_en = 1'b1;
      push_frame(16'h7FFF, 10'h1FF, 3'd7, 16'h8000, 10'h200, 3'd7);
      wait_drain(200, 1);
      push_frame(16'h1234, 10'h123, 3'd5, 16'h0100, 10'h100, 3'd1);
      wait_drain(200, 1);
      push_frame(16'hFFC0, 10'h3C0, 3'd1, 16'h0000, 10'h000, 3'd1);
      wait_drain(200, 1);
      push_frame(16'h0200, 10'h100, 3'd2, 16'h0000, 10'h000, 3'd1);
      wait_drain(200, 1);

      // Three frames queued at once: gapless output, ready low while full.
      run_q.delete();
      f0 = falls;
      push_frame(16'h1234, 10'h123, 3'd5, 16'h0100, 10'h100, 3'd1);
      push_frame(16'h8000, 10'h200, 3'd7, 16'h0000, 10'h000, 3'd1);
      push_frame(16'hFFC0, 10'h3C0, 3'd1, 16'h7FFF, 10'h1FF, 3'd7);
      wait_drain(400, 1);
      chk("burst_falls", falls - f0, 1);
      chk("burst_accepts", acc_cnt, 7);
      chk("burst_runs", run_q.size(), 3);
      if (run_q.size() == 3) begin
         chk("run_first", run_q[0], 1);
         chk("run_f2", run_q[1], 31);
         chk("run_f3", run_q[2], 31);
      end

      push_frame(16'hC000, 10'h200, 3'd6, 16'h0003, 10'h003, 3'd1);
      wait_drain(1200, 3);
      chk("cen_period", cyc_period, 48);

      // Reset at bit 7 of ch1, then a fresh frame must start cleanly.
      mon_en = 1'b0;
      feed_q.push_back({16'hFFC0, 16'h7FFF});
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         found = sync && ch;
      end
      chk("found_ch1", found, 1);
      repeat (7) step();
      rst = 1'b1;
      step();
      chk("mrst_sd", sd, 0);
      chk("mrst_sync", sync, 0);
      chk("mrst_ch", ch, 0);
      chk("mrst_man", man, 0);
      chk("mrst_exp", exp, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_ready", bus.din_ready, 0);
      rst = 1'b0;
      step();
      chk("mrst_ready_rel", bus.din_ready, 1);
      chk("mrst_busy_rel", busy, 0);
      mon_en = 1'b1;
      push_frame(16'h1234, 10'h123, 3'd5, 16'h8000, 10'h200, 3'd7);
      wait_drain(200, 1);

      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule
